cordic_iter_sched: RTL and testbench

- Synchronous scheduler that shares one iterative CORDIC square-root datapath between two requesters.
- Round-robin arbiter grants one job at a time. The sequencer then issues ITERS micro-iterations, each carrying the hyperbolic shift amount and its repeat flag, with shift 4, 13, 40, ... issued twice.
- Ends each job with a completion handshake tagged with the owner id.
- Sits between the requester front-ends and the datapath; the datapath only consumes shift_amnt/iter_* and never counts itself.

---
 rtl/cordic_iter_sched_if.sv | 32 +++
 rtl/cordic_iter_sched.sv | 134 +++++++++++++
 tb/tb_cordic_iter_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_sched_if.sv
// Handshake bundle between requesters, the shared CORDIC datapath, the completion consumer
// and the iteration scheduler.
interface cordic_iter_sched_if #(
    parameter int SHW = 6
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic           iter_valid;
    logic           iter_ready;
    logic [SHW-1:0] shift_amnt;
    logic           iter_first;
    logic           iter_last;
    logic           iter_repeat;
    logic           owner;
    logic           busy;
    logic           done_valid;
    logic           done_id;
    logic           done_ready;

    // master: requesters/datapath/consumer side; slave: the scheduler
    modport master (
        output req_valid, iter_ready, done_ready,
        input  req_ready, iter_valid, shift_amnt, iter_first, iter_last,
               iter_repeat, owner, busy, done_valid, done_id
    );

    modport slave (
        input  req_valid, iter_ready, done_ready,
        output req_ready, iter_valid, shift_amnt, iter_first, iter_last,
               iter_repeat, owner, busy, done_valid, done_id
    );
endinterface

// File: rtl/cordic_iter_sched.sv
// Round-robin job scheduler for a shared iterative hyperbolic CORDIC sqrt datapath.
// Issues ITERS micro-iterations per job and repeats shifts 4, 13, 40, ... once each.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational on req_valid
// RUN   | presenting micro-iterations to the datapath
// DONE  | holding done_valid until the consumer takes it
module cordic_iter_sched #(
    parameter int ITERS = 18,
    parameter int SHW   = 6
) (
    input  logic clk,
    input  logic rst,
    cordic_iter_sched_if.slave bus
);
    localparam int CW = $clog2(ITERS + 1);
    localparam int RW = SHW + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [SHW-1:0] shift, shift_nxt;
    logic [RW-1:0]  rep, rep_nxt;
    logic           repeat_q, repeat_nxt;
    logic           owner_q, owner_nxt;
    logic           rr_ptr, rr_nxt;
    logic           busy_q, busy_nxt;
    logic           done_valid_q, done_valid_nxt;
    logic           done_id_q, done_id_nxt;
    logic [1:0]     grant;
    logic           gnt_id;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shift_nxt      = shift;
        rep_nxt        = rep;
        repeat_nxt     = repeat_q;
        owner_nxt      = owner_q;
        rr_nxt         = rr_ptr;
        busy_nxt       = busy_q;
        done_valid_nxt = done_valid_q;
        done_id_nxt    = done_id_q;
        grant          = 2'b00;
        gnt_id         = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;

        case (state)
            IDLE: begin
                if (|bus.req_valid && !rst) begin
                    grant[gnt_id] = 1'b1;
                    owner_nxt     = gnt_id;
                    rr_nxt        = ~gnt_id;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = CW'(1);
                    shift_nxt     = SHW'(1);
                    rep_nxt       = RW'(4);
                    repeat_nxt    = 1'b0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (bus.iter_ready) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt      = DONE;
                        done_valid_nxt = 1'b1;
                        done_id_nxt    = owner_q;
                        repeat_nxt     = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        // the first visit of a repeat shift is followed by its duplicate
                        if ({2'b00, shift} == rep && !repeat_q) begin
                            repeat_nxt = 1'b1;
                            rep_nxt    = RW'(3) * rep + RW'(1);
                        end else begin
                            shift_nxt  = shift + SHW'(1);
                            repeat_nxt = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    done_valid_nxt = 1'b0;
                    busy_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= CW'(1);
            shift        <= SHW'(1);
            rep          <= RW'(4);
            repeat_q     <= 1'b0;
            owner_q      <= 1'b0;
            rr_ptr       <= 1'b0;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            shift        <= shift_nxt;
            rep          <= rep_nxt;
            repeat_q     <= repeat_nxt;
            owner_q      <= owner_nxt;
            rr_ptr       <= rr_nxt;
            busy_q       <= busy_nxt;
            done_valid_q <= done_valid_nxt;
            done_id_q    <= done_id_nxt;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.iter_valid  = (state == RUN);
    assign bus.shift_amnt  = shift;
    assign bus.iter_first  = (state == RUN) && (cnt == CW'(1));
    assign bus.iter_last   = (state == RUN) && (cnt == CNT_LAST);
    assign bus.iter_repeat = repeat_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_id     = done_id_q;

    a_req_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
    a_iter_run:   assert property (@(posedge clk) disable iff (rst) bus.iter_valid |-> state == RUN);
    a_done_state: assert property (@(posedge clk) disable iff (rst) bus.done_valid |-> state == DONE);
endmodule

// File: tb/tb_cordic_iter_sched.sv
// Self-checking bench for cordic_iter_sched: table-driven jobs, hand-written corner
// sequences and randomized jobs against a behavioural shift-sequence/arbitration model.
module tb_cordic_iter_sched;
    localparam int ITERS = 18;
    localparam int SHW   = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_iter_sched_if #(.SHW(SHW)) bus ();
    cordic_iter_sched_if #(.SHW(SHW)) bus2 ();

    cordic_iter_sched #(.ITERS(ITERS), .SHW(SHW)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    cordic_iter_sched #(.ITERS(2), .SHW(SHW)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [1:0] req;
        logic [1:0] after;
        int         mode;
        int         stall;
        int         exp_g;
    } job_t;

    job_t tbl[7];
    int   checks = 0;
    int   errors = 0;
    int   exp_shift[ITERS];
    int   exp_rep[ITERS];
    int   pref = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected schedule: shifts count up from 1; each of 4, 13, 40, ... appears twice.
    task automatic build_seq();
        int s = 1;
        int r = 4;
        int i = 0;
        while (i < ITERS) begin
            exp_shift[i] = s; exp_rep[i] = 0; i++;
            if (s == r && i < ITERS) begin
                exp_shift[i] = s; exp_rep[i] = 1; i++;
                r = 3 * r + 1;
            end
            s++;
        end
    endtask

    function automatic int model_grant(input logic [1:0] req);
        return req[pref] ? pref : 1 - pref;
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_job(input logic [1:0] req, input logic [1:0] after,
                           input int mode, input int stall, input int exp_g);
        int waited = 0;
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        bus.req_valid = req; bus.iter_ready = 1'b0; bus.done_ready = 1'b0;
        #1;
        chk("busy_before_grant", bus.busy, 0);
        while (bus.req_ready == 2'b00 && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        chk("grant_latency", waited, 0);
        chk("req_ready", bus.req_ready, 32'(1 << exp_g));
        pref = 1 - exp_g;
        @(negedge clk);
        bus.req_valid = after;
        while (idx < ITERS && cyc < 400) begin
            bus.iter_ready = pick(mode, cyc);
            #1;
            chk("iter_valid", bus.iter_valid, 1);
            chk("shift_amnt", bus.shift_amnt, exp_shift[idx]);
            chk("iter_repeat", bus.iter_repeat, exp_rep[idx]);
            chk("iter_first", bus.iter_first, (idx == 0) ? 1 : 0);
            chk("iter_last", bus.iter_last, (idx == ITERS - 1) ? 1 : 0);
            chk("owner", bus.owner, exp_g);
            chk("busy_run", bus.busy, 1);
            chk("req_ready_run", bus.req_ready, 0);
            chk("done_valid_run", bus.done_valid, 0);
            if (bus.iter_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("iter_timeout", (idx == ITERS) ? 1 : 0, 1);
        bus.iter_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            bus.done_ready = (s == stall);
            #1;
            chk("done_valid", bus.done_valid, 1);
            chk("done_id", bus.done_id, exp_g);
            chk("req_ready_done", bus.req_ready, 0);
            chk("busy_done", bus.busy, 1);
            chk("iter_valid_done", bus.iter_valid, 0);
            if (s < stall) @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_iter_valid"}, bus.iter_valid, 0);
        chk({tag, "_shift"}, bus.shift_amnt, 1);
        chk({tag, "_first"}, bus.iter_first, 0);
        chk({tag, "_last"}, bus.iter_last, 0);
        chk({tag, "_repeat"}, bus.iter_repeat, 0);
        chk({tag, "_owner"}, bus.owner, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done_valid"}, bus.done_valid, 0);
        chk({tag, "_done_id"}, bus.done_id, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{req: 2'b01, after: 2'b00, mode: 0, stall: 0, exp_g: 0};
        tbl[1] = '{req: 2'b01, after: 2'b00, mode: 1, stall: 1, exp_g: 0};
        tbl[2] = '{req: 2'b11, after: 2'b11, mode: 0, stall: 0, exp_g: 1};
        tbl[3] = '{req: 2'b11, after: 2'b11, mode: 0, stall: 0, exp_g: 0};
        tbl[4] = '{req: 2'b11, after: 2'b11, mode: 1, stall: 2, exp_g: 1};
        tbl[5] = '{req: 2'b11, after: 2'b10, mode: 0, stall: 5, exp_g: 0};
        tbl[6] = '{req: 2'b10, after: 2'b00, mode: 0, stall: 0, exp_g: 1};

        rst = 1'b1;
        bus.req_valid = 2'b11; bus.iter_ready = 1'b0; bus.done_ready = 1'b0;
        bus2.req_valid = 2'b00; bus2.iter_ready = 1'b0; bus2.done_ready = 1'b0;
        build_seq();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0; bus.req_valid = 2'b00;

        for (int i = 0; i < 7; i++)
            run_job(tbl[i].req, tbl[i].after, tbl[i].mode, tbl[i].stall, tbl[i].exp_g);

        repeat (2) begin
            @(negedge clk);
            bus.done_ready = 1'b0;
            #1;
            chk("idle_req_ready", bus.req_ready, 0);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done_valid", bus.done_valid, 0);
        end

        // reset while iteration 7 is on the bus
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        chk("mid_grant", bus.req_ready, 1);
        pref = 1;
        for (int idx = 0; idx < 7; idx++) begin
            @(negedge clk);
            bus.req_valid = 2'b00; bus.iter_ready = 1'b1;
            #1;
            chk("mid_shift", bus.shift_amnt, exp_shift[idx]);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid = 2'b11;
            #1;
            chk_reset_outputs("midrst");
        end
        @(negedge clk);
        rst = 1'b0; bus.req_valid = 2'b00; bus.iter_ready = 1'b0;
        #1;
        chk("post_rst_done_valid", bus.done_valid, 0);
        chk("post_rst_busy", bus.busy, 0);
        pref = 0;
        run_job(2'b11, 2'b00, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [1:0] rq;
            int g;
            rq = 2'($urandom_range(1, 3));
            g  = model_grant(rq);
            run_job(rq, 2'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)), g);
        end
        @(negedge clk);
        bus.done_ready = 1'b0; bus.req_valid = 2'b00;

        // ITERS=2 instance
        @(negedge clk);
        bus2.req_valid = 2'b10;
        #1;
        chk("i2_grant", bus2.req_ready, 2);
        @(negedge clk);
        bus2.req_valid = 2'b00; bus2.iter_ready = 1'b1;
        #1;
        chk("i2_valid1", bus2.iter_valid, 1);
        chk("i2_shift1", bus2.shift_amnt, 1);
        chk("i2_first1", bus2.iter_first, 1);
        chk("i2_last1", bus2.iter_last, 0);
        chk("i2_rep1", bus2.iter_repeat, 0);
        @(negedge clk);
        #1;
        chk("i2_shift2", bus2.shift_amnt, 2);
        chk("i2_first2", bus2.iter_first, 0);
        chk("i2_last2", bus2.iter_last, 1);
        chk("i2_rep2", bus2.iter_repeat, 0);
        @(negedge clk);
        bus2.iter_ready = 1'b0; bus2.done_ready = 1'b1;
        #1;
        chk("i2_done_valid", bus2.done_valid, 1);
        chk("i2_done_id", bus2.done_id, 1);
        chk("i2_iter_valid", bus2.iter_valid, 0);
        @(negedge clk);
        #1;
        chk("i2_done_clear", bus2.done_valid, 0);
        chk("i2_busy_clear", bus2.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
